// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns M-stage load/store requests into
// valid/ready bus transactions, stalls the pipeline while one is in flight,
// and produces the extended load result RDM in the DONE cycle.
module mem_access_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] RDM,
  output logic        StallMem,
  output logic        FaultM,
  output logic        BusValid,
  output logic        BusWrite,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusByteEn,
  input  logic        BusReady,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_bus_valid;
  logic        r_bus_write;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_bad_f3;
  logic        w_misalign;
  logic        w_fault;
  logic        w_issue;

  // Lane enables for the access size, shifted to the byte offset.
  function automatic logic [3:0] f_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   f_byte_en = 4'b0001 << off;
      2'b01:   f_byte_en = 4'b0011 << off;
      default: f_byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane it could land in.
  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   f_wdata = {4{d[7:0]}};
      2'b01:   f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  // Select the addressed lane of the captured word and extend it.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  f_load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  f_load_ext = {24'b0, sh[7:0]};
      3'b001:  f_load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  f_load_ext = {16'b0, sh[15:0]};
      default: f_load_ext = word;
    endcase
  endfunction

  assign w_req = MemReadM | MemWriteM;

  // Classify the requested access: legal size code and natural alignment.
  always_comb begin
    w_bad_f3 = 1'b1;
    if (MemWriteM) begin
      case (Funct3M)
        3'b000, 3'b001, 3'b010: w_bad_f3 = 1'b0;
        default:                w_bad_f3 = 1'b1;
      endcase
    end else begin
      case (Funct3M)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_bad_f3 = 1'b0;
        default:                                w_bad_f3 = 1'b1;
      endcase
    end
    w_misalign = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                 ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
  end

  assign w_fault = w_req && ((MemReadM && MemWriteM) || w_bad_f3 || w_misalign);
  assign w_issue = (r_state == S_IDLE) && w_req && !w_fault;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic; REQ waits on BusReady with no timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue)  w_next = S_REQ;
      S_REQ:   if (BusReady) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs; stall and fault are forced low while reset is asserted.
  always_comb begin
    StallMem = 1'b0;
    FaultM   = 1'b0;
    RDM      = 32'b0;
    if (RST) begin
      FaultM = (r_state == S_IDLE) && w_fault;
      case (r_state)
        S_IDLE:  StallMem = w_issue;
        S_REQ:   StallMem = 1'b1;
        S_DONE:  if (!r_bus_write) RDM = f_load_ext(r_rdata, r_f3, r_off);
        default: StallMem = 1'b0;
      endcase
    end
  end

  // Bus request registers: loaded on issue, held through REQ, valid dropped on handshake.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bus_valid <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= 32'b0;
      r_bus_wdata <= 32'b0;
      r_bus_be    <= 4'b0;
      r_f3        <= 3'b0;
      r_off       <= 2'b0;
      r_rdata     <= 32'b0;
    end else begin
      if (w_issue) begin
        r_bus_valid <= 1'b1;
        r_bus_write <= MemWriteM;
        r_bus_addr  <= {ALUResultM[31:2], 2'b00};
        r_bus_be    <= f_byte_en(Funct3M, ALUResultM[1:0]);
        r_bus_wdata <= MemWriteM ? f_wdata(Funct3M, WriteDataM) : 32'b0;
        r_f3        <= Funct3M;
        r_off       <= ALUResultM[1:0];
      end else if ((r_state == S_REQ) && BusReady) begin
        r_bus_valid <= 1'b0;
        if (!r_bus_write) r_rdata <= BusRData;
      end
    end
  end

  assign BusValid  = r_bus_valid;
  assign BusWrite  = r_bus_write;
  assign BusAddr   = r_bus_addr;
  assign BusWData  = r_bus_wdata;
  assign BusByteEn = r_bus_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single accesses plus
// hand-written reset, back-to-back and idle sequences.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] RDM;
  logic        StallMem, FaultM;
  logic        BusValid, BusWrite;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusByteEn;
  logic        BusReady;
  logic [31:0] BusRData;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RDM(RDM), .StallMem(StallMem), .FaultM(FaultM), .BusValid(BusValid),
    .BusWrite(BusWrite), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .BusReady(BusReady), .BusRData(BusRData)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic        fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdm;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                              input int dly, input logic fault, input logic [31:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erdm);
    vec_t v;
    v.name = nm; v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
    v.dly = dly; v.fault = fault; v.exp_addr = ea; v.exp_be = ebe; v.exp_wd = ewd; v.exp_rdm = erdm;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int stalls;
    stalls = 0;
    @(negedge CLK);
    MemReadM = v.mr; MemWriteM = v.mw; Funct3M = v.f3; ALUResultM = v.addr;
    WriteDataM = v.wd; BusRData = v.rd; BusReady = 1'b0;
    #1;
    chk({v.name, " fault"}, FaultM, v.fault);
    if (v.fault) begin
      chk({v.name, " fault stall"}, StallMem, 0);
      chk({v.name, " fault rdm"}, RDM, 0);
      @(posedge CLK);
      @(negedge CLK);
      chk({v.name, " fault no valid"}, BusValid, 0);
      chk({v.name, " fault rdm2"}, RDM, 0);
      MemReadM = 1'b0; MemWriteM = 1'b0;
      return;
    end
    if (StallMem) stalls++;
    @(posedge CLK);
    for (int c = 0; c <= v.dly; c++) begin
      @(negedge CLK);
      chk({v.name, " valid"}, BusValid, 1);
      chk({v.name, " write"}, BusWrite, v.mw);
      chk({v.name, " addr"}, BusAddr, v.exp_addr);
      chk({v.name, " be"}, BusByteEn, v.exp_be);
      chk({v.name, " wdata"}, BusWData, v.exp_wd);
      chk({v.name, " rdm in req"}, RDM, 0);
      if (StallMem) stalls++;
      BusReady = (c == v.dly);
      @(posedge CLK);
    end
    @(negedge CLK);
    BusReady = 1'b0;
    // The M-stage inputs may move on; RDM must come from registered state only.
    Funct3M = 3'b010; ALUResultM = 32'h0; BusRData = 32'h5555_5555;
    #1;
    chk({v.name, " done stall"}, StallMem, 0);
    chk({v.name, " done valid"}, BusValid, 0);
    chk({v.name, " rdm"}, RDM, v.exp_rdm);
    chk({v.name, " stall cycles"}, stalls, v.dly + 2);
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  logic [31:0] exp_stall[6];
  logic [31:0] exp_valid[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("LW100",  1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 0, 32'hDEADBEEF);
    vecs[1]  = mk("LB103",  1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 0, 32'h100, 4'b1000, 0, 32'hFFFFFF80);
    vecs[2]  = mk("LBU103", 1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 0, 0, 32'h100, 4'b1000, 0, 32'h00000080);
    vecs[3]  = mk("SH202",  0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 3, 0, 32'h200, 4'b1100, 32'hABCDABCD, 0);
    vecs[4]  = mk("LH102",  1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 0, 0, 32'h100, 4'b1100, 0, 32'hFFFF8001);
    vecs[5]  = mk("LHU102", 1, 0, 3'b101, 32'h102, 0, 32'h80017FFF, 1, 0, 32'h100, 4'b1100, 0, 32'h00008001);
    vecs[6]  = mk("LH100",  1, 0, 3'b001, 32'h100, 0, 32'h80017FFF, 0, 0, 32'h100, 4'b0011, 0, 32'h00007FFF);
    vecs[7]  = mk("SB001",  0, 1, 3'b000, 32'h001, 32'h000000A5, 0, 1, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 0);
    vecs[8]  = mk("SW304",  0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 0, 0, 0, 32'h304, 4'b1111, 32'hCAFEF00D, 0);
    vecs[9]  = mk("LB101",  1, 0, 3'b000, 32'h101, 0, 32'h00007F00, 2, 0, 32'h100, 4'b0010, 0, 32'h0000007F);
    vecs[10] = mk("LW101f", 1, 0, 3'b010, 32'h101, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk("LH003f", 1, 0, 3'b001, 32'h003, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk("RWf",    1, 1, 3'b010, 32'h000, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[13] = mk("SBUf",   0, 1, 3'b100, 32'h000, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[14] = mk("L011f",  1, 0, 3'b011, 32'h000, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[15] = mk("SW102f", 0, 1, 3'b010, 32'h102, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset with a load presented: stall/fault must stay low, bus registers clear.
    RST = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
    ALUResultM = 32'h100; WriteDataM = 0; BusReady = 1'b1; BusRData = 32'hFFFFFFFF;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst valid", BusValid, 0);
    chk("rst write", BusWrite, 0);
    chk("rst addr", BusAddr, 0);
    chk("rst wdata", BusWData, 0);
    chk("rst be", BusByteEn, 0);
    chk("rst rdm", RDM, 0);
    chk("rst stall", StallMem, 0);
    MemReadM = 1'b1; ALUResultM = 32'h101;
    #1 chk("rst fault", FaultM, 0);
    MemReadM = 1'b0; BusReady = 1'b0;
    RST = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a stalled REQ.
    @(negedge CLK);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h40; BusReady = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("arst pre valid", BusValid, 1);
    #1 RST = 1'b0;
    #1;
    chk("arst valid", BusValid, 0);
    chk("arst stall", StallMem, 0);
    chk("arst rdm", RDM, 0);
    chk("arst addr", BusAddr, 0);
    MemReadM = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    run_vec(mk("LW0post", 1, 0, 3'b010, 32'h0, 0, 32'h0BADF00D, 0, 0, 32'h0, 4'b1111, 0, 32'h0BADF00D));

    // Back-to-back loads with ready always high: 6 M-stage cycles.
    exp_stall = '{1, 1, 0, 1, 1, 0};
    exp_valid = '{0, 1, 0, 0, 1, 0};
    @(negedge CLK);
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h10;
    BusReady = 1'b1; BusRData = 32'h11111111;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge CLK);
      #1;
      chk($sformatf("b2b stall c%0d", c), StallMem, exp_stall[c]);
      chk($sformatf("b2b valid c%0d", c), BusValid, exp_valid[c]);
      if (c == 1) chk("b2b addr0", BusAddr, 32'h10);
      if (c == 4) chk("b2b addr1", BusAddr, 32'h14);
      if (c == 2) begin
        chk("b2b rdm0", RDM, 32'h11111111);
        ALUResultM = 32'h14; BusRData = 32'h22222222;
      end
      if (c == 5) begin
        chk("b2b rdm1", RDM, 32'h22222222);
        MemReadM = 1'b0;
      end
    end
    BusReady = 1'b0;

    // Non-memory instruction in IDLE leaves the bus registers untouched.
    @(negedge CLK);
    ALUResultM = 32'hFFFFFFFF; WriteDataM = 32'h12345678; Funct3M = 3'b000;
    #1;
    chk("nop stall", StallMem, 0);
    chk("nop fault", FaultM, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("nop addr", BusAddr, 32'h14);
    chk("nop valid", BusValid, 0);
    chk("nop be", BusByteEn, 4'b1111);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the pipelined RISC-V core. It sits between the execute/memory pipeline register and the writeback register. It turns MemReadM/MemWriteM requests into transactions on a valid/ready data bus and produces the load result RDM that the writeback register captures. While a transaction is outstanding it stalls the pipeline, and it flags misaligned or illegal accesses instead of issuing them.

## Interface
- No parameters; address and data are fixed at 32 bits.
- CLK  in  1  clock; every register updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load request in the M stage.
- MemWriteM  in  1  store request in the M stage.
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- RDM  out  32  load result, extended to 32 bits; valid in DONE.
- StallMem  out  1  freezes PC and the F/D/E/M pipeline registers.
- FaultM  out  1  access is misaligned or illegal; no bus transaction is issued.
- BusValid  out  1  request valid.
- BusWrite  out  1  1 = write, 0 = read.
- BusAddr  out  32  word address; bits [1:0] are always 0.
- BusWData  out  32  lane-replicated write data.
- BusByteEn  out  4  byte lane enables.
- BusReady  in  1  responder accepts/completes the request; for reads, BusRData is valid in the same cycle.
- BusRData  in  32  read data.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- An access is requested when MemReadM or MemWriteM is 1.
- FaultM is combinational and is 1 when an access is requested and any of these hold:
  - MemReadM and MemWriteM are both 1.
  - Funct3M is not a legal value: loads allow 000/001/010/100/101; stores allow 000/001/010.
  - H/HU with ALUResultM[0] equal to 1.
  - W with ALUResultM[1:0] not equal to 0.
- A faulted access:
  - issues no bus transaction;
  - gives StallMem=0 and RDM=0;
  - leaves the FSM in IDLE.
- IDLE, with a non-faulted access requested:
  - StallMem=1 (combinational).
  - On the clock edge, register BusAddr={ALUResultM[31:2],2'b00}, BusWrite=MemWriteM, BusByteEn and BusWData, and set BusValid=1. Next state is REQ.
- Byte enables: B/BU gives 4'b0001<<addr[1:0]. H/HU gives 4'b0011<<addr[1:0]. W gives 4'b1111. Reads register the same enables.
- Write data: B replicates WriteDataM[7:0] four times. H replicates WriteDataM[15:0] twice. W passes it through unchanged. For reads BusWData=0.
- REQ:
  - StallMem=1.
  - BusValid and all Bus* outputs are held stable.
  - On an edge where BusReady=1: capture BusRData (reads only), clear BusValid, go to DONE.
  - With BusReady=0 the unit waits indefinitely; there is no timeout.
- DONE:
  - StallMem=0, so the pipeline advances on this edge and REG_W samples RDM.
  - Next state is IDLE unconditionally.
- RDM in DONE for reads: select the lane of the captured word using the registered offset, then extend.
  - B sign-extends bits [7:0] of the selected lane.
  - BU zero-extends bits [7:0].
  - H sign-extends the selected 16 bits; HU zero-extends them.
  - W passes the word through.
- RDM is 0 outside DONE and in DONE for writes.
- Funct3, offset and read/write are registered at IDLE→REQ. RDM does not depend on the M-stage inputs after issue.

## Timing
- Reset values:
  - BusValid=0, BusWrite=0, BusAddr=0, BusWData=0, BusByteEn=0, captured data=0, RDM=0.
  - StallMem and FaultM are forced to 0 while RST=0.
- Minimum access is 3 cycles in M: IDLE (stall), REQ with BusReady=1 (stall), DONE (release).
- Each cycle BusReady stays low in REQ adds one stall cycle.
- BusValid is a registered output. It rises on the edge leaving IDLE and falls on the edge where BusReady=1 is sampled. BusReady is ignored while BusValid=0.
- Back-to-back accesses: the next instruction is seen in IDLE on the cycle after DONE, so there is no bus request in DONE.
- An asynchronous reset during REQ or DONE returns the FSM to IDLE and drops BusValid immediately. The outstanding bus transaction is abandoned; the responder must tolerate this.
- Non-memory instructions in IDLE: StallMem=0, FaultM=0, and no Bus* register changes.

## Test plan
- LW at 0x100, BusReady=1 in the first REQ cycle, BusRData=0xDEADBEEF:
  - BusAddr=0x100, BusByteEn=1111.
  - StallMem is high for exactly 2 cycles.
  - RDM=0xDEADBEEF in DONE.
- LB at 0x103 with BusRData=0x80FF_0000 → BusByteEn=1000, RDM=0xFFFFFF80. LBU at the same address → RDM=0x00000080.
- SH at 0x202, WriteDataM=0x1234ABCD, BusReady held low 3 cycles in REQ:
  - BusAddr=0x200, BusByteEn=1100, BusWData=0xABCDABCD.
  - Bus* outputs stay stable; StallMem is high for 5 cycles.
  - RDM=0.
- LW at 0x101, then LH at 0x003, then MemReadM=MemWriteM=1:
  - FaultM=1 and StallMem=0 in each case.
  - BusValid never rises; RDM=0.
- RST pulled low during REQ with BusValid=1:
  - BusValid=0, StallMem=0, RDM=0 at once.
  - After release, an LW at 0x0 completes normally.
- Two consecutive LW instructions (0x10, 0x14), ready always 1:
  - Two distinct bus transactions.
  - DONE of the first is followed by IDLE of the second; total 6 M-stage cycles.
